// File: rtl/stack_alu_core_if.sv
// Command/result bundle for stack_alu_core.
//   master: drives in_valid, opcode, input_data; observes in_ready and the result fields.
//   slave : the core; drives in_ready, out_valid, output_data, overflow, invalid, depth.
interface stack_alu_core_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1024
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] input_data;
    logic             out_valid;
    logic [WIDTH-1:0] output_data;
    logic             overflow;
    logic             invalid;
    logic [CW-1:0]    depth;

    modport master (
        output in_valid, opcode, input_data,
        input  in_ready, out_valid, output_data, overflow, invalid, depth
    );

    modport slave (
        input  in_valid, opcode, input_data,
        output in_ready, out_valid, output_data, overflow, invalid, depth
    );
endinterface

// File: rtl/stack_alu_core.sv
// LIFO operand stack with push/pop/dup/swap, add/sub and a shift-add signed multiply.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus_io - command handshake (in_valid/in_ready/opcode/input_data) and registered result
//            (out_valid pulse, output_data, overflow, invalid, depth)
module stack_alu_core #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1024
) (
    input logic              clk,
    input logic              rst_n,
    stack_alu_core_if.slave  bus_io
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned NW = $clog2(WIDTH);

    localparam logic [2:0] OpNop  = 3'b000;
    localparam logic [2:0] OpSub  = 3'b001;
    localparam logic [2:0] OpDup  = 3'b010;
    localparam logic [2:0] OpSwap = 3'b011;
    localparam logic [2:0] OpAdd  = 3'b100;
    localparam logic [2:0] OpMul  = 3'b101;
    localparam logic [2:0] OpPush = 3'b110;
    localparam logic [2:0] OpPop  = 3'b111;

    typedef enum logic {StIdle, StMulRun} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      depth_q, depth_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               ovf_q, ovf_d;
    logic               inv_q, inv_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d;
    logic [NW-1:0]      cnt_q, cnt_d;

    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic               wr_a_en, wr_b_en;
    logic [AW-1:0]      wr_a_addr, wr_b_addr;
    logic [WIDTH-1:0]   wr_a_data, wr_b_data;

    logic [AW-1:0]      top_addr, tos_addr, nos_addr;
    logic [WIDTH-1:0]   tos, nos, sum, diff;
    logic               has1, has2, full;
    logic [2*WIDTH-1:0] acc_step, prod;
    logic               mul_ovf;

    // Magnitude of a two's-complement word; the most negative value maps to 2^(WIDTH-1),
    // which is still exact when read as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? ({WIDTH{1'b0}} - x) : x;
    endfunction

    assign top_addr = depth_q[AW-1:0];
    assign tos_addr = AW'(depth_q - CW'(1));
    assign nos_addr = AW'(depth_q - CW'(2));
    assign tos      = mem_q[tos_addr];
    assign nos      = mem_q[nos_addr];
    assign sum      = nos + tos;
    assign diff     = nos - tos;
    assign has1     = depth_q >= CW'(1);
    assign has2     = depth_q >= CW'(2);
    assign full     = depth_q == CW'(DEPTH);

    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign prod     = neg_q ? ({(2*WIDTH){1'b0}} - acc_step) : acc_step;
    // Fits in WIDTH signed bits only if the upper WIDTH+1 bits are all copies of the sign.
    assign mul_ovf  = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));

    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        out_valid_d = 1'b0;
        data_d      = data_q;
        ovf_d       = ovf_q;
        inv_d       = inv_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        neg_d       = neg_q;
        cnt_d       = cnt_q;
        wr_a_en     = 1'b0;
        wr_a_addr   = '0;
        wr_a_data   = '0;
        wr_b_en     = 1'b0;
        wr_b_addr   = '0;
        wr_b_data   = '0;

        unique case (state_q)
            StIdle: begin
                if (bus_io.in_valid && bus_io.opcode != OpNop) begin
                    // Rejected commands report zero data and no overflow.
                    out_valid_d = 1'b1;
                    data_d      = '0;
                    ovf_d       = 1'b0;
                    inv_d       = 1'b0;
                    case (bus_io.opcode)
                        OpAdd: begin
                            if (has2) begin
                                data_d = sum;
                                ovf_d  = (nos[WIDTH-1] == tos[WIDTH-1]) &&
                                         (sum[WIDTH-1] != nos[WIDTH-1]);
                            end else inv_d = 1'b1;
                        end
                        OpSub: begin
                            if (has2) begin
                                data_d = diff;
                                ovf_d  = (nos[WIDTH-1] != tos[WIDTH-1]) &&
                                         (diff[WIDTH-1] != nos[WIDTH-1]);
                            end else inv_d = 1'b1;
                        end
                        OpMul: begin
                            if (has2) begin
                                // Result fields hold until the product registers.
                                out_valid_d = 1'b0;
                                data_d      = data_q;
                                ovf_d       = ovf_q;
                                inv_d       = inv_q;
                                state_d     = StMulRun;
                                acc_d       = '0;
                                mcand_d     = {{WIDTH{1'b0}}, mag(nos)};
                                mplier_d    = mag(tos);
                                neg_d       = nos[WIDTH-1] ^ tos[WIDTH-1];
                                cnt_d       = '0;
                            end else inv_d = 1'b1;
                        end
                        OpSwap: begin
                            if (has2) begin
                                data_d    = nos;
                                wr_a_en   = 1'b1;
                                wr_a_addr = tos_addr;
                                wr_a_data = nos;
                                wr_b_en   = 1'b1;
                                wr_b_addr = nos_addr;
                                wr_b_data = tos;
                            end else inv_d = 1'b1;
                        end
                        OpDup: begin
                            if (has1 && !full) begin
                                data_d    = tos;
                                wr_a_en   = 1'b1;
                                wr_a_addr = top_addr;
                                wr_a_data = tos;
                                depth_d   = depth_q + CW'(1);
                            end else inv_d = 1'b1;
                        end
                        OpPush: begin
                            if (!full) begin
                                data_d    = bus_io.input_data;
                                wr_a_en   = 1'b1;
                                wr_a_addr = top_addr;
                                wr_a_data = bus_io.input_data;
                                depth_d   = depth_q + CW'(1);
                            end else inv_d = 1'b1;
                        end
                        OpPop: begin
                            if (has1) begin
                                data_d  = tos;
                                depth_d = depth_q - CW'(1);
                            end else inv_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            StMulRun: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + NW'(1);
                if (cnt_q == NW'(WIDTH - 1)) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b1;
                    data_d      = prod[WIDTH-1:0];
                    ovf_d       = mul_ovf;
                    inv_d       = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            depth_q     <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            ovf_q       <= 1'b0;
            inv_q       <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            ovf_q       <= ovf_d;
            inv_q       <= inv_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
        end
    end

    // Stack storage is deliberately not reset; only entries below depth are ever read.
    always_ff @(posedge clk) begin
        if (wr_a_en) mem_q[wr_a_addr] <= wr_a_data;
        if (wr_b_en) mem_q[wr_b_addr] <= wr_b_data;
    end

    assign bus_io.in_ready    = (state_q == StIdle);
    assign bus_io.out_valid   = out_valid_q;
    assign bus_io.output_data = data_q;
    assign bus_io.overflow    = ovf_q;
    assign bus_io.invalid     = inv_q;
    assign bus_io.depth       = depth_q;

endmodule

// File: doc/stack_alu_core.md
# stack_alu_core

Parametrised successor to the 32-bit stack ALU: a LIFO operand stack of DEPTH words of WIDTH bits with push, pop, dup, swap, add, subtract and a multi-cycle signed multiply. Commands arrive on a valid/ready handshake, and every accepted command except NOP returns exactly one result beat. It sits in the datapath as the evaluation engine behind the command decoder. Overflow uses true two's-complement detection, and the multiply is a bounded shift-add sequencer instead of a repeated-add loop.

## Interface
- WIDTH, 32, data word width (≥ 4)
- DEPTH, 1024, stack entries (power of two, ≥ 4); count width CW = log2(DEPTH)+1
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  command present
- in_ready  out  1  core can accept a command this cycle
- opcode  in  3  000 NOP, 001 SUB, 010 DUP, 011 SWAP, 100 ADD, 101 MUL, 110 PUSH, 111 POP
- input_data  in  WIDTH  signed operand for PUSH
- out_valid  out  1  one-cycle pulse: result fields valid
- output_data  out  WIDTH  signed result
- overflow  out  1  signed overflow of the result
- invalid  out  1  command rejected (underflow or full)
- depth  out  CW  current number of stack entries

## Operation
- Accept means in_valid && in_ready at a rising edge. NOP is accepted, changes nothing and produces no out_valid.
- TOS = stack[depth-1], NOS = stack[depth-2].
- ADD, SUB and MUL read TOS and NOS and leave the stack unmodified.
  - ADD result: NOS+TOS.
  - SUB result: NOS−TOS.
  - MUL result: NOS×TOS.
- Overflow rules:
  - ADD and SUB: set when the WIDTH-bit result's sign is wrong, i.e. the exact result lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - MUL: set when the 2·WIDTH-bit exact product does not fit in WIDTH signed bits; output_data is the low WIDTH bits.
- PUSH: stack[depth] ← input_data, depth+1; output_data = input_data.
- POP: depth−1; output_data = the popped value.
- DUP: pushes a copy of TOS; output_data = TOS.
- SWAP: exchanges TOS and NOS; output_data = new TOS.
- Invalid conditions:
  - ADD, SUB, MUL, SWAP with depth < 2.
  - POP and DUP with depth = 0.
  - PUSH and DUP with depth = DEPTH.
  - In each case: invalid=1, output_data=0, overflow=0, and stack and depth are unchanged.
- For every valid result, invalid=0. Overflow is 0 for PUSH, POP, DUP and SWAP.
- output_data, overflow and invalid hold their value between out_valid pulses.
- FSM:
  - IDLE: in_ready=1. A valid MUL goes to MUL_RUN; every other command is completed in IDLE.
  - MUL_RUN: in_ready=0. Operands are latched as magnitudes with the result sign XOR, plus an iteration counter. One shift-add step is performed per cycle.
  - After WIDTH steps, the product is sign-corrected, registered with out_valid, and the FSM returns to IDLE.
- Stack RAM is not cleared by reset. Locations at or above depth are never read as results.

## Timing
- Reset values: in_ready=1, out_valid=0, output_data=0, overflow=0, invalid=0, depth=0, FSM=IDLE.
- Non-MUL commands, and MUL rejected as invalid: result and depth update at the accept edge. out_valid is high for the following cycle, so latency is 1 cycle.
- A new command may be accepted every cycle in IDLE; back-to-back commands see each other's stack updates.
- Valid MUL accepted at edge E0: in_ready is low from E0 to E_WIDTH; the result registers at E_WIDTH, so out_valid is high in the cycle after E_WIDTH.
  - in_ready returns high at E_WIDTH, so the next command can be accepted at edge E_WIDTH+1.
  - Latency is WIDTH cycles. The stack cannot change during MUL.
- Commands presented while in_ready=0 are not accepted; the source must hold them.
- rst_n asserted mid-MUL: the operation aborts immediately with no out_valid and all outputs at their reset values.

## Test plan
- Reset, then PUSH 5, PUSH 7, ADD -> out_valid pulses with 5, 7 and then 12; depth=2; overflow=0; invalid=0.
- WIDTH=32: PUSH 0x7FFFFFFF, PUSH 1, ADD -> output 0x80000000, overflow=1. Then POP, PUSH −1, SUB -> 0x80000000, overflow=1.
- PUSH −3, PUSH 4, MUL -> in_ready low for 32 cycles, output −12, overflow=0. Then PUSH 0x10000, DUP, MUL -> output 0, overflow=1.
- Empty stack: POP, ADD, SWAP -> each gives invalid=1, output 0, depth stays 0. After DEPTH pushes (DEPTH=4 build), PUSH and DUP -> invalid=1, depth=4.
- PUSH 1, PUSH 2, SWAP, POP, POP -> outputs 1, 1, 2, with depth ending at 0.
- Start MUL, drop rst_n on cycle 10 -> no out_valid, in_ready=1, depth=0. A subsequent PUSH 9 gives output 9 with 1-cycle latency.
